peripheral_adder_pipeline: RTL

Parametrised, elastic, pipelined unsigned adder/subtractor for the peripheral datapath. It generalises the fixed 8-bit adder to DATA_WIDTH operands with a configurable pipeline depth. It adds four arithmetic modes (wrap/saturate, add/sub), an overflow flag, valid/ready flow control with backpressure, and a completed-transaction counter. It sits between a request producer and a result consumer on the peripheral bus side.

---
 rtl/peripheral_adder_pipeline.sv | 110 +++++++++++
 1 files changed

// File: rtl/peripheral_adder_pipeline.sv
// Elastic pipelined unsigned adder/subtractor: wrap or saturating add/sub computed into
// stage 1, then carried through PIPE_STAGES registers with collapsing bubbles.
module peripheral_adder_pipeline #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] ip1,
  input  logic [DATA_WIDTH-1:0] ip2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  txn_count
);

  localparam int W = DATA_WIDTH;
  localparam int N = PIPE_STAGES;

  logic [W:0]          sum;
  logic [W:0]          diff;
  logic                borrow;
  logic [W:0]          res;
  logic                res_ov;

  logic [N-1:0]        v;
  logic [N-1:0]        load;
  logic [N-1:0][W:0]   st_d;
  logic [N-1:0]        st_ov;
  logic [N:0]          chain_v;
  logic [N:0][W:0]     chain_d;
  logic [N:0]          chain_ov;
  logic                tail_full;

  // With W+1 bit operands the difference's top bit is exactly the borrow (ip1 < ip2).
  assign sum    = {1'b0, ip1} + {1'b0, ip2};
  assign diff   = {1'b0, ip1} - {1'b0, ip2};
  assign borrow = diff[W];

  always_comb begin
    res    = sum;
    res_ov = sum[W];
    case (mode)
      2'b00: begin
        res    = sum;
        res_ov = sum[W];
      end
      2'b01: begin
        res    = diff;
        res_ov = borrow;
      end
      2'b10: begin
        res    = sum[W] ? {1'b0, {W{1'b1}}} : sum;
        res_ov = sum[W];
      end
      default: begin
        res    = borrow ? '0 : diff;
        res_ov = borrow;
      end
    endcase
  end

  // Index 0 of each chain is the incoming beat; index k+1 is the register of stage k.
  assign chain_v  = {v, in_valid};
  assign chain_d  = {st_d, res};
  assign chain_ov = {st_ov, res_ov};

  // Handshake rule (both ports): a beat transfers on a rising clk edge where valid and
  // ready are both 1; valid never depends on ready, while in_ready depends on out_ready.
  // A stage may load unless it and every stage downstream is full and the output stalls.
  always_comb begin
    tail_full = 1'b1;
    load      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      tail_full = tail_full & v[i];
      load[i]   = out_ready | ~tail_full;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[N-1];
  assign out       = st_d[N-1];
  assign overflow  = st_ov[N-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v         <= '0;
      st_d      <= '0;
      st_ov     <= '0;
      txn_count <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          v[i]     <= chain_v[i];
          st_d[i]  <= chain_d[i];
          st_ov[i] <= chain_ov[i];
        end
      end
      if (out_valid && out_ready) begin
        txn_count <= txn_count + 1'b1;
      end
    end
  end

endmodule
